psum_accumulator: RTL and testbench

//  Downstream of the 5x5 PE groups. Accumulates a run of 18-bit signed group sums
//  (kernel rows x input channels) into one output-pixel sum, then adds bias.
//  The result is requantized to an 8-bit activation (round, ReLU, saturate) and

---
 rtl/psum_accumulator.sv | 116 +++++++++++
 tb/tb_psum_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Output-pixel accumulator: sums a run of signed group sums on top of a bias,
// then rounds, optionally ReLUs and saturates to an 8-bit activation.
module psum_accumulator #(
  parameter int IN_W   = 18,
  parameter int ACC_W  = 24,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     start,
  input  logic [5:0]               num_terms,
  input  logic signed [BIAS_W-1:0] bias_in,
  input  logic [3:0]               shift,
  input  logic                     relu_en,
  input  logic                     psum_valid,
  input  logic signed [IN_W-1:0]   psum_in,
  output logic                     psum_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -ACC_W'(2 ** (OUT_W - 1));

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [5:0]                cnt;
  logic [5:0]                n_terms;
  logic [3:0]                shift_q;
  logic                      relu_q;
  logic signed [ACC_W-1:0]   acc_sum;

  // Round half up, arithmetic shift, optional ReLU, then saturate to OUT_W.
  function automatic logic signed [OUT_W-1:0] quantize(
    input logic signed [ACC_W-1:0] v,
    input logic [3:0]              sh,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] r;
    r = v;
    if (sh != 4'd0) begin
      rnd = ACC_W'(1) << (sh - 4'd1);
      r   = v + rnd;
      r   = r >>> sh;
    end
    if (relu && r < 0) r = '0;
    if (r > OUT_MAX)      r = OUT_MAX;
    else if (r < OUT_MIN) r = OUT_MIN;
    return r[OUT_W-1:0];
  endfunction

  assign acc_sum    = acc + ACC_W'(psum_in);
  assign psum_ready = (state == S_ACCUM);
  assign busy       = (state != S_IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      n_terms   <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && num_terms != 6'd0) begin
            n_terms <= num_terms;
            shift_q <= shift;
            relu_q  <= relu_en;
            acc     <= ACC_W'(bias_in);
            cnt     <= '0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (psum_valid) begin
            acc <= acc_sum;
            cnt <= cnt + 6'd1;
            // The last term is folded in combinationally so the result lands one edge later.
            if (cnt == n_terms - 6'd1) begin
              out_data  <= quantize(acc_sum, shift_q, relu_q);
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: transaction-level model of each
// pixel (plain integer sum + requantization) compared against the DUT every cycle.
module tb_psum_accumulator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              start = 1'b0;
  logic [5:0]        num_terms = '0;
  logic signed [15:0] bias_in = '0;
  logic [3:0]        shift = '0;
  logic              relu_en = 1'b0;
  logic              psum_valid = 1'b0;
  logic signed [17:0] psum_in = '0;
  logic              psum_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_data;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected observable state, updated by the driver after each edge it causes.
  bit exp_ready = 0;
  bit exp_valid = 0;
  bit exp_busy  = 0;
  int exp_data  = 0;

  int ps[64];

  psum_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .start      (start),
    .num_terms  (num_terms),
    .bias_in    (bias_in),
    .shift      (shift),
    .relu_en    (relu_en),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .psum_ready (psum_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int quant(input longint f, input int sh, input bit relu);
    longint r;
    r = f;
    if (sh > 0) r = (f + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  always @(negedge clk) begin
    check("psum_ready", psum_ready, exp_ready);
    check("busy", busy, exp_busy);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", int'(out_data), exp_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pixel(input int n, input int bias, input int sh, input bit relu);
    start = 1'b1; num_terms = 6'(n); bias_in = 16'(bias); shift = 4'(sh); relu_en = relu;
    step();
    exp_busy = 1; exp_ready = 1;
    start = 1'b0;
    // Scramble config inputs: the DUT must use the values latched at start.
    num_terms = 6'($urandom); shift = 4'($urandom); relu_en = 1'($urandom);
    bias_in = 16'($urandom);
  endtask

  task automatic feed(input int i, input int gap_pct);
    for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
      psum_valid = 1'b0; psum_in = 18'($urandom);
      step();
    end
    psum_valid = 1'b1; psum_in = 18'(ps[i]);
    step();
    psum_valid = 1'b0;
  endtask

  task automatic run_pixel(input int n, input int bias, input int sh, input bit relu,
                           input int stall, input int gap_pct);
    longint sum;
    sum = bias;
    for (int i = 0; i < n; i++) sum += ps[i];
    begin_pixel(n, bias, sh, relu);
    for (int i = 0; i < n; i++) begin
      feed(i, gap_pct);
      if (i == n - 1) begin
        exp_ready = 0; exp_valid = 1; exp_data = quant(sum, sh, relu);
      end
    end
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      start = 1'($urandom); num_terms = 6'($urandom_range(1, 63));
      psum_valid = 1'($urandom); psum_in = 18'($urandom);
      step();
    end
    start = 1'b0; psum_valid = 1'b0; out_ready = 1'b1;
    step();
    exp_valid = 0; exp_busy = 0;
    out_ready = 1'b0;
  endtask

  task automatic abort_test(input bit use_reset);
    ps[0] = 11; ps[1] = -3;
    begin_pixel(5, 9, 0, 0);
    feed(0, 0);
    feed(1, 0);
    if (use_reset) begin
      rst_n = 1'b0;
      exp_ready = 0; exp_valid = 0; exp_busy = 0;
      #1;
      check("rst_mid psum_ready", psum_ready, 0);
      check("rst_mid out_valid", out_valid, 0);
      check("rst_mid out_data", int'(out_data), 0);
      check("rst_mid busy", busy, 0);
      step();
      #2 rst_n = 1'b1;
      step();
    end else begin
      clr = 1'b1;
      step();
      exp_ready = 0; exp_valid = 0; exp_busy = 0;
      clr = 1'b0;
      step();
    end
    ps[0] = 0;
    run_pixel(1, 7, 0, 0, 0, 0);
  endtask

  initial begin
    // Pin the reference model with hand-computed values.
    check("model T1", quant(60, 0, 1), 60);
    check("model T2 relu", quant(-40, 0, 1), 0);
    check("model T2 norelu", quant(-40, 0, 0), -40);
    check("model T3 pos", quant(131071, 4, 0), 127);
    check("model T3 neg", quant(-131072, 4, 0), -128);
    check("model T4 24", quant(24, 4, 0), 2);
    check("model T4 23", quant(23, 4, 0), 1);
    check("model T4 -24", quant(-24, 4, 0), -1);
    check("model T4 bias", quant(100, 0, 0), 100);
    check("model T6", quant(7, 0, 0), 7);

    repeat (3) step();
    check("reset out_data", int'(out_data), 0);
    check("reset out_valid", out_valid, 0);
    check("reset psum_ready", psum_ready, 0);
    check("reset busy", busy, 0);
    #2 rst_n = 1'b1;
    step();

    // Idle: zero-length start and stray psums must be ignored.
    start = 1'b1; num_terms = 6'd0; psum_valid = 1'b1;
    step();
    start = 1'b0; psum_valid = 1'b0;
    step();

    ps[0] = 10; ps[1] = 20; ps[2] = 30;
    run_pixel(3, 0, 0, 1, 0, 0);
    ps[0] = -50; ps[1] = 10;
    run_pixel(2, 0, 0, 1, 0, 0);
    run_pixel(2, 0, 0, 0, 0, 0);
    ps[0] = 131071;  run_pixel(1, 0, 4, 0, 0, 0);
    ps[0] = -131072; run_pixel(1, 0, 4, 0, 0, 0);
    ps[0] = 24;  run_pixel(1, 0, 4, 0, 0, 0);
    ps[0] = 23;  run_pixel(1, 0, 4, 0, 0, 0);
    ps[0] = -24; run_pixel(1, 0, 4, 0, 0, 0);
    ps[0] = 0;   run_pixel(1, 100, 0, 0, 0, 0);
    ps[0] = 5; ps[1] = 6;
    run_pixel(2, 1, 0, 0, 5, 0);

    abort_test(1);
    abort_test(0);

    for (int t = 0; t < 40; t++) begin
      int n;
      n = (t % 8 == 0) ? 63 : int'($urandom_range(1, 63));
      for (int i = 0; i < n; i++) ps[i] = int'($urandom_range(0, 262143)) - 131072;
      if (t % 5 == 0) for (int i = 0; i < n; i++) ps[i] = ps[i] >>> 10;
      run_pixel(n, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
                1'($urandom), int'($urandom_range(0, 3)), 25);
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
